// File: rtl/tlul_host_arb_if.sv
// ----------------------------------------------------------------------------
// tlul_host_arb_if: single-beat TL-UL types and the multi-host bundle. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam tl_h2d_t TL_H2D_DEFAULT = '{d_ready: 1'b1, default: '0};

endpackage

interface tlul_host_arb_if #(
  parameter int NumHosts = 2
);
  import tlul_pkg::*;

  tl_h2d_t tl_h_i [NumHosts];
  tl_d2h_t tl_h_o [NumHosts];
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_d_i;

  // slave: the arbiter's view; master: hosts plus device driving the arbiter
  modport slave  (input  tl_h_i, tl_d_i, output tl_h_o, tl_d_o);
  modport master (output tl_h_i, tl_d_i, input  tl_h_o, tl_d_o);

endinterface

`default_nettype wire

// File: rtl/tlul_host_arb.sv
// ----------------------------------------------------------------------------
// tlul_host_arb: round-robin TL-UL host arbiter with in-order D steering. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tlul_host_arb
  import tlul_pkg::*;
#(
  parameter int NumHosts       = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  tlul_host_arb_if.slave                    bus,
  output logic [$clog2(MaxOutstanding):0]   outstanding_o,
  output logic                              rsp_err_o
);

  localparam int HostIdxW = $clog2(NumHosts);
  localparam int PtrW     = $clog2(MaxOutstanding);
  localparam int CntW     = PtrW + 1;

  logic [HostIdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic                lock_q;
  logic [HostIdxW-1:0] lock_idx_q;
  logic [HostIdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic                rsp_err_q;

  logic [NumHosts-1:0] req_vec;
  logic [HostIdxW-1:0] scan_idx, grant, head;
  logic                scan_hit, has_req, full, cnt_nz;
  logic                a_valid_dev, a_fire, a_stall, d_fire, orphan;
  logic [31:0]         cand;

  always_comb begin
    req_vec = '0;
    for (int h = 0; h < NumHosts; h++) begin
      req_vec[h] = bus.tl_h_i[h].a_valid;
    end
  end

  // Scan starts at rr_ptr and wraps modulo NumHosts (not necessarily a power of two)
  always_comb begin
    scan_idx = rr_ptr_q;
    scan_hit = 1'b0;
    cand     = '0;
    for (int i = 0; i < NumHosts; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NumHosts) cand = cand - NumHosts;
      if (!scan_hit && req_vec[cand[HostIdxW-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = cand[HostIdxW-1:0];
      end
    end
  end

  assign grant       = lock_q ? lock_idx_q : scan_idx;
  assign has_req     = lock_q ? req_vec[lock_idx_q] : scan_hit;
  assign full        = (count_q == CntW'(MaxOutstanding));
  assign cnt_nz      = (count_q != '0);
  assign head        = fifo_q[rd_ptr_q];

  assign a_valid_dev = has_req & ~full & ~rst_i;
  assign a_fire      = a_valid_dev & bus.tl_d_i.a_ready;
  assign a_stall     = a_valid_dev & ~bus.tl_d_i.a_ready;
  assign d_fire      = ~rst_i & bus.tl_d_i.d_valid & cnt_nz & bus.tl_h_i[head].d_ready;
  assign orphan      = ~rst_i & bus.tl_d_i.d_valid & ~cnt_nz;

  always_comb begin
    bus.tl_d_o = TL_H2D_DEFAULT;
    if (has_req) bus.tl_d_o = bus.tl_h_i[grant];
    bus.tl_d_o.a_valid = a_valid_dev;
    // With nothing in flight a stray response is sunk rather than stalling the device
    bus.tl_d_o.d_ready = ~rst_i & (cnt_nz ? bus.tl_h_i[head].d_ready : 1'b1);
  end

  always_comb begin
    for (int g = 0; g < NumHosts; g++) begin
      bus.tl_h_o[g]         = bus.tl_d_i;
      bus.tl_h_o[g].d_valid = ~rst_i & bus.tl_d_i.d_valid & cnt_nz &
                              (head == HostIdxW'(g));
      bus.tl_h_o[g].a_ready = ~rst_i & bus.tl_d_i.a_ready & ~full &
                              (grant == HostIdxW'(g));
    end
  end

  always_comb begin
    rr_ptr_d = (grant == HostIdxW'(NumHosts - 1)) ? '0 : grant + 1'b1;
    count_d  = count_q;
    if (a_fire && !d_fire)      count_d = count_q + 1'b1;
    else if (!a_fire && d_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rsp_err_q  <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      if (a_fire) begin
        fifo_q[wr_ptr_q] <= grant;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        rr_ptr_q         <= rr_ptr_d;
        lock_q           <= 1'b0;
      end else if (a_stall) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end
      if (d_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      rsp_err_q <= orphan;
    end
  end

  assign outstanding_o = count_q;
  assign rsp_err_o     = rsp_err_q & ~rst_i;

endmodule

`default_nettype wire

// File: tb/tb_tlul_host_arb.sv
// ----------------------------------------------------------------------------
// tb_tlul_host_arb: scoreboard bench for the two-host TL-UL arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tlul_host_arb;
  import tlul_pkg::*;

  localparam int NH = 2;
  localparam int MO = 4;
  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] outst;
  logic       rsp_err;

  always #5 clk = ~clk;

  tlul_host_arb_if #(.NumHosts(NH)) bus ();

  tlul_host_arb #(.NumHosts(NH), .MaxOutstanding(MO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus.slave),
    .outstanding_o (outst),
    .rsp_err_o     (rsp_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          host;
    logic [7:0]  src;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  src;
    logic [31:0] data;
  } rsp_t;

  exp_t exp_q [$];
  rsp_t dev_q [$];
  int   grant_log [$];
  int   host_left [NH];
  int   seq [NH];

  logic          dev_ar = 1'b0, rsp_en = 1'b0, spur = 1'b0;
  logic          dev_av_seen, dev_dr_seen, rsp_err_seen;
  logic [7:0]    dev_src_seen;
  logic [2:0]    outst_seen, outst_after;
  logic [NH-1:0] hdv_seen, hard_seen;

  task automatic load_req(input int h);
    bus.tl_h_i[h].a_valid   = 1'b1;
    bus.tl_h_i[h].a_opcode  = 3'd4;
    bus.tl_h_i[h].a_param   = 3'd0;
    bus.tl_h_i[h].a_size    = 2'd2;
    bus.tl_h_i[h].a_source  = 8'((h << 5) | seq[h]);
    bus.tl_h_i[h].a_address = 32'(32'h1000 * (h + 1) + seq[h] * 4);
    bus.tl_h_i[h].a_mask    = 4'hf;
    bus.tl_h_i[h].a_data    = $urandom;
    bus.tl_h_i[h].a_user    = 16'h0;
    seq[h] = (seq[h] + 1) % 32;
  endtask

  // One cycle: observe at negedge, let the edge happen, then drive the next inputs
  task automatic tick();
    int            nfire;
    int            fh;
    logic [NH-1:0] fired;
    exp_t          e;
    rsp_t          r;
    @(negedge clk);
    nfire = 0;
    fh    = 0;
    fired = '0;
    for (int h = 0; h < NH; h++) begin
      hdv_seen[h]  = bus.tl_h_o[h].d_valid;
      hard_seen[h] = bus.tl_h_o[h].a_ready;
      if (bus.tl_h_i[h].a_valid && bus.tl_h_o[h].a_ready) begin
        nfire++;
        fh       = h;
        fired[h] = 1'b1;
        e.host   = h;
        e.src    = bus.tl_h_i[h].a_source;
        e.data   = bus.tl_h_i[h].a_data ^ KEY;
        exp_q.push_back(e);
      end
    end
    dev_av_seen  = bus.tl_d_o.a_valid;
    dev_src_seen = bus.tl_d_o.a_source;
    dev_dr_seen  = bus.tl_d_o.d_ready;
    outst_seen   = outst;
    rsp_err_seen = rsp_err;
    if (bus.tl_d_o.a_valid && bus.tl_d_i.a_ready) begin
      chk("a_one_host", nfire, 1);
      chk("a_src_pass", bus.tl_d_o.a_source, bus.tl_h_i[fh].a_source);
      chk("a_data_pass", bus.tl_d_o.a_data, bus.tl_h_i[fh].a_data);
      grant_log.push_back(fh);
      r.src  = bus.tl_d_o.a_source;
      r.data = bus.tl_d_o.a_data ^ KEY;
      dev_q.push_back(r);
    end else if (nfire != 0) begin
      chk("a_ready_stray", nfire, 0);
    end
    for (int h = 0; h < NH; h++) begin
      if (bus.tl_h_o[h].d_valid && bus.tl_h_i[h].d_ready) begin
        if (exp_q.size() == 0) begin
          chk("d_unexpected_host", h, 32'hff);
        end else begin
          e = exp_q.pop_front();
          chk("d_host", h, e.host);
          chk("d_src", bus.tl_h_o[h].d_source, e.src);
          chk("d_data", bus.tl_h_o[h].d_data, e.data);
        end
      end
    end
    if (bus.tl_d_i.d_valid && bus.tl_d_o.d_ready && dev_q.size() > 0)
      r = dev_q.pop_front();
    @(posedge clk);
    #1;
    outst_after = outst;
    for (int h = 0; h < NH; h++) begin
      if (fired[h] || !bus.tl_h_i[h].a_valid) begin
        if (host_left[h] > 0) begin
          host_left[h]--;
          load_req(h);
        end else begin
          bus.tl_h_i[h].a_valid = 1'b0;
        end
      end
    end
    bus.tl_d_i         = '0;
    bus.tl_d_i.a_ready = dev_ar;
    if (spur) begin
      bus.tl_d_i.d_valid  = 1'b1;
      bus.tl_d_i.d_source = 8'hee;
      bus.tl_d_i.d_data   = 32'hdead_beef;
    end else if (rsp_en && dev_q.size() > 0) begin
      bus.tl_d_i.d_valid    = 1'b1;
      bus.tl_d_i.d_opcode   = 3'd1;
      bus.tl_d_i.d_size     = 2'd2;
      bus.tl_d_i.d_source   = dev_q[0].src;
      bus.tl_d_i.d_data     = dev_q[0].data;
    end
  endtask

  function automatic bit busy();
    busy = (exp_q.size() > 0);
    for (int h = 0; h < NH; h++)
      if (host_left[h] > 0 || bus.tl_h_i[h].a_valid) busy = 1'b1;
  endfunction

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (busy() && n < max) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy()}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int h = 0; h < NH; h++) begin
      host_left[h] = 0;
      seq[h]       = 0;
    end
    // Reset with every input active: all handshakes must still be held low
    rst = 1'b1;
    for (int h = 0; h < NH; h++) begin
      load_req(h);
      bus.tl_h_i[h].d_ready = 1'b1;
    end
    bus.tl_d_i         = '0;
    bus.tl_d_i.a_ready = 1'b1;
    bus.tl_d_i.d_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dev_a_valid", bus.tl_d_o.a_valid, 0);
    chk("rst_dev_d_ready", bus.tl_d_o.d_ready, 0);
    chk("rst_h0_a_ready", bus.tl_h_o[0].a_ready, 0);
    chk("rst_h1_a_ready", bus.tl_h_o[1].a_ready, 0);
    chk("rst_h0_d_valid", bus.tl_h_o[0].d_valid, 0);
    chk("rst_h1_d_valid", bus.tl_h_o[1].d_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    for (int h = 0; h < NH; h++) begin
      bus.tl_h_i[h].a_valid = 1'b0;
      seq[h] = 0;
    end
    bus.tl_d_i = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("idle_a_valid", dev_av_seen, 0);
    chk("idle_outstanding", outst_seen, 0);
    chk("idle_a_ready", hard_seen, 0);

    // Both hosts requesting continuously: grants alternate starting at host 0
    dev_ar = 1'b1;
    rsp_en = 1'b1;
    host_left[0] = 4;
    host_left[1] = 4;
    drain("rr_drain", 80);
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) chk("rr_alternate", grant_log[i], i % 2);

    // Host 1 stalls at the device; host 0 arriving later must not steal the grant
    grant_log.delete();
    dev_ar = 1'b0;
    host_left[1] = 1;
    tick();
    host_left[0] = 1;
    tick();
    tick();
    chk("lock_valid", dev_av_seen, 1);
    chk("lock_host_c2", dev_src_seen[7:5], 1);
    dev_ar = 1'b1;
    tick();
    chk("lock_host_c3", dev_src_seen[7:5], 1);
    drain("lock_drain", 40);
    chk("lock_count", grant_log.size(), 2);
    chk("lock_first", grant_log[0], 1);
    chk("lock_second", grant_log[1], 0);

    // Fill to MaxOutstanding with responses held back
    grant_log.delete();
    rsp_en = 1'b0;
    host_left[0] = 5;
    repeat (7) tick();
    chk("full_accepted", grant_log.size(), MO);
    chk("full_outstanding", outst_seen, MO);
    chk("full_a_valid", dev_av_seen, 0);
    chk("full_a_ready", hard_seen, 0);
    rsp_en = 1'b1;
    tick();
    tick();
    chk("full_no_bypass", dev_av_seen, 0);
    chk("full_no_bypass_cnt", grant_log.size(), MO);
    tick();
    chk("full_after_pop", dev_av_seen, 1);
    chk("full_fifth", grant_log.size(), MO + 1);
    drain("full_drain", 40);

    // Simultaneous push and pop at two in flight
    grant_log.delete();
    rsp_en = 1'b0;
    host_left[0] = 1;
    host_left[1] = 1;
    repeat (4) tick();
    chk("pp_setup", outst_seen, 2);
    host_left[1] = 1;
    rsp_en = 1'b1;
    tick();
    tick();
    chk("pp_before", outst_seen, 2);
    chk("pp_after", outst_after, 2);
    chk("pp_head_route", hdv_seen, 32'(1 << grant_log[0]));
    chk("pp_grant", grant_log[2], 1);
    host_left[0] = 1;
    host_left[1] = 1;
    drain("pp_drain", 40);
    chk("pp_rr_next0", grant_log[3], 0);
    chk("pp_rr_next1", grant_log[4], 1);

    // Response with nothing in flight: sunk, flagged one cycle later for one cycle
    rsp_en = 1'b0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    chk("orphan_no_d_valid", hdv_seen, 0);
    chk("orphan_d_ready", dev_dr_seen, 1);
    chk("orphan_err_same", rsp_err_seen, 0);
    tick();
    chk("orphan_err_pulse", rsp_err_seen, 1);
    tick();
    chk("orphan_err_clear", rsp_err_seen, 0);
    chk("orphan_outstanding", outst_seen, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
